// File: rtl/wb_trace_checker_pkg.sv
// Shared encodings and the queued trace-entry layout for the write-back trace checker.
package wb_trace_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FAIL = 2'd2
   } chk_state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE      = 2'd0,
      CAUSE_DATA      = 2'd1,
      CAUSE_UNDERFLOW = 2'd2,
      CAUSE_COLLISION = 2'd3
   } fail_cause_t;

   typedef enum logic {
      KIND_RF = 1'b0,
      KIND_DM = 1'b1
   } entry_kind_t;

   localparam int ENTRY_W = 75;

   // The valid bit guards against ever matching a slot that was never written.
   typedef struct packed {
      logic        valid;
      entry_kind_t kind;
      logic [4:0]  dest;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  wen;
   } trace_entry_t;

   function automatic logic rf_match(trace_entry_t e, logic [4:0] dest, logic [31:0] data);
      return e.valid && (e.kind == KIND_RF) && (e.dest == dest) && (e.data == data);
   endfunction

   function automatic logic dm_match(trace_entry_t e, logic [31:0] addr, logic [31:0] data,
                                     logic [3:0] wen);
      return e.valid && (e.kind == KIND_DM) && (e.addr == addr) && (e.data == data) &&
             (e.wen == wen);
   endfunction

endpackage

// File: rtl/wb_trace_checker_trace_fifo.sv
// Power-of-two FIFO for expected trace entries; a push while full is taken when a pop frees the slot.
module trace_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 75
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = 1;
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wb_trace_checker.sv
// Compares retiring CPU register/memory writes against a queue of expected entries.
module wb_trace_checker
   import wb_trace_checker_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        exp_valid,
   output logic        exp_ready,
   input  logic        exp_kind,
   input  logic [4:0]  exp_dest,
   input  logic [31:0] exp_addr,
   input  logic [31:0] exp_data,
   input  logic [3:0]  exp_wen,
   input  logic        check_en,
   input  logic        debug_rf_wen,
   input  logic [4:0]  debug_rf_wdest,
   input  logic [31:0] debug_rf_wdata,
   input  logic [3:0]  debug_dm_wen,
   input  logic [31:0] debug_dm_addr,
   input  logic [31:0] debug_dm_wdata,
   output logic [1:0]  state,
   output logic        err,
   output logic [15:0] match_count,
   output logic [15:0] fail_idx,
   output logic [1:0]  fail_cause
);

   chk_state_t   state_q;
   fail_cause_t  cause_q;
   logic         err_q;
   logic [15:0]  match_q;
   logic [15:0]  fail_idx_q;

   trace_entry_t push_entry;
   trace_entry_t head;
   logic         fifo_full;
   logic         fifo_empty;
   logic         fifo_push;
   logic         fifo_pop;
   logic         rf_evt;
   logic         dm_evt;
   logic         in_run;
   logic         head_match;

   assign rf_evt = debug_rf_wen && (debug_rf_wdest != 5'd0);
   assign dm_evt = (debug_dm_wen != 4'b0000);
   assign in_run = (state_q == ST_RUN);

   assign push_entry = '{valid: 1'b1, kind: entry_kind_t'(exp_kind), dest: exp_dest,
                         addr: exp_addr, data: exp_data, wen: exp_wen};

   // Collisions and underflows never consume an entry; a single event pops exactly one.
   assign fifo_pop  = in_run && (rf_evt ^ dm_evt) && !fifo_empty;
   assign exp_ready = !fifo_full;
   assign fifo_push = exp_valid && (exp_ready || fifo_pop);

   assign head_match = rf_evt ? rf_match(head, debug_rf_wdest, debug_rf_wdata)
                              : dm_match(head, debug_dm_addr, debug_dm_wdata, debug_dm_wen);

   trace_fifo #(
      .DEPTH(DEPTH),
      .WIDTH(ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .resetn(resetn),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (push_entry),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Checker FSM: the verdict for an event cycle lands on the following edge; FAIL holds until reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         cause_q    <= CAUSE_NONE;
         err_q      <= 1'b0;
         match_q    <= '0;
         fail_idx_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (check_en) begin
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (rf_evt && dm_evt) begin
                  state_q    <= ST_FAIL;
                  cause_q    <= CAUSE_COLLISION;
                  err_q      <= 1'b1;
                  fail_idx_q <= match_q;
               end else if (rf_evt || dm_evt) begin
                  if (fifo_empty) begin
                     state_q    <= ST_FAIL;
                     cause_q    <= CAUSE_UNDERFLOW;
                     err_q      <= 1'b1;
                     fail_idx_q <= match_q;
                  end else if (head_match) begin
                     if (match_q != 16'hFFFF) begin
                        match_q <= match_q + 16'd1;
                     end
                  end else begin
                     state_q    <= ST_FAIL;
                     cause_q    <= CAUSE_DATA;
                     err_q      <= 1'b1;
                     fail_idx_q <= match_q;
                  end
               end else if (!check_en) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_FAIL;
            end
         endcase
      end
   end

   assign state       = state_q;
   assign err         = err_q;
   assign match_count = match_q;
   assign fail_idx    = fail_idx_q;
   assign fail_cause  = cause_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed bench for wb_trace_checker: a vector table for the basic flow plus corner-case sequences.
module tb_wb_trace_checker;

   localparam int DEPTH = 8;

   logic        clk;
   logic        resetn;
   logic        exp_valid;
   logic        exp_ready;
   logic        exp_kind;
   logic [4:0]  exp_dest;
   logic [31:0] exp_addr;
   logic [31:0] exp_data;
   logic [3:0]  exp_wen;
   logic        check_en;
   logic        debug_rf_wen;
   logic [4:0]  debug_rf_wdest;
   logic [31:0] debug_rf_wdata;
   logic [3:0]  debug_dm_wen;
   logic [31:0] debug_dm_addr;
   logic [31:0] debug_dm_wdata;
   logic [1:0]  state;
   logic        err;
   logic [15:0] match_count;
   logic [15:0] fail_idx;
   logic [1:0]  fail_cause;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic        kind;
      logic [4:0]  dest;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  wen;
   } ent_t;

   typedef struct {
      logic        push;
      logic [4:0]  p_dest;
      logic [31:0] p_data;
      logic        chk;
      logic        ev;
      logic [4:0]  e_dest;
      logic [31:0] e_data;
      int          gap;
      logic [1:0]  x_state;
      logic [15:0] x_mc;
      logic        x_err;
      logic        x_ready;
   } vec_t;

   vec_t tbl [12];

   wb_trace_checker #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .exp_valid     (exp_valid),
      .exp_ready     (exp_ready),
      .exp_kind      (exp_kind),
      .exp_dest      (exp_dest),
      .exp_addr      (exp_addr),
      .exp_data      (exp_data),
      .exp_wen       (exp_wen),
      .check_en      (check_en),
      .debug_rf_wen  (debug_rf_wen),
      .debug_rf_wdest(debug_rf_wdest),
      .debug_rf_wdata(debug_rf_wdata),
      .debug_dm_wen  (debug_dm_wen),
      .debug_dm_addr (debug_dm_addr),
      .debug_dm_wdata(debug_dm_wdata),
      .state         (state),
      .err           (err),
      .match_count   (match_count),
      .fail_idx      (fail_idx),
      .fail_cause    (fail_cause)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic apply_stimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      exp_valid      = 1'b0;
      exp_kind       = 1'b0;
      exp_dest       = '0;
      exp_addr       = '0;
      exp_data       = '0;
      exp_wen        = '0;
      debug_rf_wen   = 1'b0;
      debug_rf_wdest = '0;
      debug_rf_wdata = '0;
      debug_dm_wen   = '0;
      debug_dm_addr  = '0;
      debug_dm_wdata = '0;
   endtask

   function automatic ent_t gen_entry(input int i);
      ent_t e;
      int   b;
      b      = i;
      e.kind = b[0];
      e.dest = 5'((i % 31) + 1);
      e.addr = 32'h8000_0000 + 32'(i * 4);
      e.data = 32'h1000_0000 + 32'(i * 3);
      e.wen  = 4'(1 << (i % 4));
      return e;
   endfunction

   task automatic push_ent(input ent_t e);
      exp_valid = 1'b1;
      exp_kind  = e.kind;
      exp_dest  = e.dest;
      exp_addr  = e.addr;
      exp_data  = e.data;
      exp_wen   = e.wen;
   endtask

   task automatic event_ent(input ent_t e);
      if (e.kind == 1'b0) begin
         debug_rf_wen   = 1'b1;
         debug_rf_wdest = e.dest;
         debug_rf_wdata = e.data;
      end else begin
         debug_dm_wen   = e.wen;
         debug_dm_addr  = e.addr;
         debug_dm_wdata = e.data;
      end
   endtask

   task automatic push_rf(input logic [4:0] dest, input logic [31:0] data);
      exp_valid = 1'b1;
      exp_kind  = 1'b0;
      exp_dest  = dest;
      exp_data  = data;
   endtask

   task automatic event_rf(input logic [4:0] dest, input logic [31:0] data);
      debug_rf_wen   = 1'b1;
      debug_rf_wdest = dest;
      debug_rf_wdata = data;
   endtask

   task automatic do_reset();
      clear_inputs();
      check_en = 1'b0;
      resetn   = 1'b0;
      apply_stimulus();
      apply_stimulus();
      resetn = 1'b1;
   endtask

   initial begin
      ent_t e;

      // Reset values, seen asynchronously before any clock edge
      clear_inputs();
      check_en = 1'b0;
      resetn   = 1'b0;
      #1;
      check_output("reset state", 32'(state), 32'd0);
      check_output("reset err", 32'(err), 32'd0);
      check_output("reset fail_cause", 32'(fail_cause), 32'd0);
      check_output("reset match_count", 32'(match_count), 32'd0);
      check_output("reset fail_idx", 32'(fail_idx), 32'd0);
      check_output("reset exp_ready", 32'(exp_ready), 32'd1);
      apply_stimulus();
      resetn = 1'b1;

      // push, chk, ev, gap, state, mc, err, ready
      tbl[0]  = '{1'b1, 5'd16, 32'h0000AAAA, 1'b0, 1'b0, 5'd0,  32'h0,        0, 2'd0, 16'd0, 1'b0, 1'b1};
      tbl[1]  = '{1'b1, 5'd8,  32'hFFFF5555, 1'b0, 1'b0, 5'd0,  32'h0,        0, 2'd0, 16'd0, 1'b0, 1'b1};
      tbl[2]  = '{1'b1, 5'd9,  32'h0000AAAB, 1'b0, 1'b0, 5'd0,  32'h0,        0, 2'd0, 16'd0, 1'b0, 1'b1};
      tbl[3]  = '{1'b1, 5'd10, 32'h0000AAAC, 1'b0, 1'b0, 5'd0,  32'h0,        0, 2'd0, 16'd0, 1'b0, 1'b1};
      tbl[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd0,  32'h0,        0, 2'd1, 16'd0, 1'b0, 1'b1};
      tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 5'd16, 32'h0000AAAA, 4, 2'd1, 16'd1, 1'b0, 1'b1};
      tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 5'd0,  32'hDEADBEEF, 0, 2'd1, 16'd1, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 5'd8,  32'hFFFF5555, 4, 2'd1, 16'd2, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 5'd9,  32'h0000AAAB, 4, 2'd1, 16'd3, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 5'd10, 32'h0000AAAC, 4, 2'd1, 16'd4, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  32'h0,        0, 2'd0, 16'd4, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd5,  32'h00000005, 0, 2'd0, 16'd4, 1'b0, 1'b1};

      for (int i = 0; i < 12; i++) begin
         clear_inputs();
         check_en = tbl[i].chk;
         if (tbl[i].push) push_rf(tbl[i].p_dest, tbl[i].p_data);
         if (tbl[i].ev) event_rf(tbl[i].e_dest, tbl[i].e_data);
         apply_stimulus();
         check_output($sformatf("row%0d state", i), 32'(state), 32'(tbl[i].x_state));
         check_output($sformatf("row%0d match_count", i), 32'(match_count), 32'(tbl[i].x_mc));
         check_output($sformatf("row%0d err", i), 32'(err), 32'(tbl[i].x_err));
         check_output($sformatf("row%0d exp_ready", i), 32'(exp_ready), 32'(tbl[i].x_ready));
         clear_inputs();
         for (int g = 0; g < tbl[i].gap; g++) apply_stimulus();
      end

      // Data mismatch on the very first compare
      do_reset();
      push_rf(5'd1, 32'h00000001);
      apply_stimulus();
      clear_inputs();
      check_en = 1'b1;
      apply_stimulus();
      event_rf(5'd1, 32'h00000002);
      apply_stimulus();
      clear_inputs();
      check_output("mismatch state", 32'(state), 32'd2);
      check_output("mismatch cause", 32'(fail_cause), 32'd1);
      check_output("mismatch fail_idx", 32'(fail_idx), 32'd0);
      check_output("mismatch err", 32'(err), 32'd1);
      push_rf(5'd2, 32'h00000005);
      event_rf(5'd2, 32'h00000005);
      apply_stimulus();
      clear_inputs();
      event_rf(5'd2, 32'h00000005);
      apply_stimulus();
      clear_inputs();
      check_output("fail absorbing match_count", 32'(match_count), 32'd0);
      check_output("fail absorbing state", 32'(state), 32'd2);
      check_output("fail absorbing cause", 32'(fail_cause), 32'd1);

      // Mismatch after two matches, on a memory write with wrong byte enables
      do_reset();
      push_rf(5'd3, 32'h3);
      apply_stimulus();
      push_rf(5'd3, 32'h3);
      apply_stimulus();
      clear_inputs();
      e = '{kind: 1'b1, dest: 5'd0, addr: 32'h40, data: 32'hDEAD, wen: 4'h3};
      push_ent(e);
      apply_stimulus();
      clear_inputs();
      check_en = 1'b1;
      apply_stimulus();
      event_rf(5'd3, 32'h3);
      apply_stimulus();
      clear_inputs();
      event_rf(5'd3, 32'h3);
      apply_stimulus();
      clear_inputs();
      e.wen = 4'hF;
      event_ent(e);
      apply_stimulus();
      clear_inputs();
      check_output("dm wen mismatch cause", 32'(fail_cause), 32'd1);
      check_output("dm wen mismatch fail_idx", 32'(fail_idx), 32'd2);
      check_output("dm wen mismatch match_count", 32'(match_count), 32'd2);

      // Underflow: event with nothing queued
      do_reset();
      check_en = 1'b1;
      apply_stimulus();
      event_rf(5'd3, 32'h3);
      apply_stimulus();
      clear_inputs();
      check_output("underflow cause", 32'(fail_cause), 32'd2);
      check_output("underflow err", 32'(err), 32'd1);
      check_output("underflow state", 32'(state), 32'd2);

      // Collision: RF and DM event together, nothing popped
      do_reset();
      push_rf(5'd4, 32'h44);
      apply_stimulus();
      push_rf(5'd5, 32'h55);
      apply_stimulus();
      clear_inputs();
      check_en = 1'b1;
      apply_stimulus();
      event_rf(5'd4, 32'h44);
      debug_dm_wen   = 4'hF;
      debug_dm_addr  = 32'h100;
      debug_dm_wdata = 32'h44;
      apply_stimulus();
      clear_inputs();
      check_output("collision cause", 32'(fail_cause), 32'd3);
      check_output("collision state", 32'(state), 32'd2);
      for (int i = 0; i < DEPTH - 3; i++) begin
         push_ent(gen_entry(i));
         apply_stimulus();
      end
      clear_inputs();
      check_output("collision occupancy not full", 32'(exp_ready), 32'd1);
      push_ent(gen_entry(7));
      apply_stimulus();
      clear_inputs();
      check_output("collision occupancy full", 32'(exp_ready), 32'd0);

      // Full FIFO with push+pop every cycle across several pointer wraps
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         push_ent(gen_entry(i));
         apply_stimulus();
      end
      clear_inputs();
      check_output("full exp_ready", 32'(exp_ready), 32'd0);
      check_en = 1'b1;
      apply_stimulus();
      event_rf(5'd0, 32'h12345678);
      apply_stimulus();
      clear_inputs();
      check_output("r0 ignored match_count", 32'(match_count), 32'd0);
      check_output("r0 ignored state", 32'(state), 32'd1);
      check_output("r0 ignored exp_ready", 32'(exp_ready), 32'd0);
      for (int k = 0; k < 3 * DEPTH; k++) begin
         clear_inputs();
         push_ent(gen_entry(DEPTH + k));
         event_ent(gen_entry(k));
         apply_stimulus();
         check_output($sformatf("push+pop %0d exp_ready", k), 32'(exp_ready), 32'd0);
      end
      clear_inputs();
      check_output("wrap match_count", 32'(match_count), 32'(3 * DEPTH));
      check_output("wrap err", 32'(err), 32'd0);
      for (int k = 0; k < DEPTH; k++) begin
         clear_inputs();
         event_ent(gen_entry(3 * DEPTH + k));
         apply_stimulus();
      end
      clear_inputs();
      check_output("drain match_count", 32'(match_count), 32'(4 * DEPTH));
      check_output("drain exp_ready", 32'(exp_ready), 32'd1);
      check_output("drain state", 32'(state), 32'd1);
      check_output("drain err", 32'(err), 32'd0);

      // Reset mid-RUN discards queued entries
      do_reset();
      for (int i = 0; i < 4; i++) begin
         push_ent(gen_entry(i));
         apply_stimulus();
      end
      clear_inputs();
      check_en = 1'b1;
      apply_stimulus();
      event_ent(gen_entry(0));
      apply_stimulus();
      clear_inputs();
      check_output("pre-reset match_count", 32'(match_count), 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      check_output("mid reset state", 32'(state), 32'd0);
      check_output("mid reset err", 32'(err), 32'd0);
      check_output("mid reset cause", 32'(fail_cause), 32'd0);
      check_output("mid reset match_count", 32'(match_count), 32'd0);
      check_output("mid reset fail_idx", 32'(fail_idx), 32'd0);
      check_output("mid reset exp_ready", 32'(exp_ready), 32'd1);
      apply_stimulus();
      resetn   = 1'b1;
      check_en = 1'b1;
      apply_stimulus();
      event_ent(gen_entry(1));
      apply_stimulus();
      clear_inputs();
      check_output("post reset underflow cause", 32'(fail_cause), 32'd2);
      check_output("post reset underflow state", 32'(state), 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
